// File: rtl/xs3_pkg.sv
// Shared definitions for the serial Excess-3 decoder: bit-index state encoding
// and the code constants used by the subtractor and the range check.
package xs3_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } xs3_state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'b0011;
  localparam logic [3:0] XS3_MAX    = 4'b1100;

  // Subtrahend bit for the given bit index (bit k of XS3_OFFSET).
  function automatic logic xs3_k(input xs3_state_t st);
    return XS3_OFFSET[st];
  endfunction

endpackage

// File: rtl/xs3_serial_sub.sv
// One-bit serial borrow subtractor cell: s = x - k - bin, with borrow out.
module xs3_serial_sub (
  input  logic x,
  input  logic k,
  input  logic bin,
  output logic s,
  output logic bout
);

  always_comb begin
    s    = x ^ k ^ bin;
    bout = (~x & (k | bin)) | (k & bin);
  end

endmodule

// File: rtl/serial_xs3_decoder.sv
// Serial Excess-3 to BCD decoder, LSB first, 4 bits per digit, falling-edge clocked.
// Define XS3_ERR_COUNT_EN to add the saturating ERR_CNT invalid-digit counter.
module serial_xs3_decoder
  import xs3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       X,
  input  logic       X_VALID,
  input  logic       SYNC,
  output logic       S,
  output logic       V,
  output logic [3:0] D,
  output logic       D_VALID,
  output logic       ERR
`ifdef XS3_ERR_COUNT_EN
  ,
  output logic [7:0] ERR_CNT
`endif
);

  xs3_state_t state, state_next, cur;
  logic       borrow, borrow_in, borrow_out, k, s_raw;
  logic [2:0] shift, xin;
  logic [3:0] code;

  xs3_serial_sub u_sub (
    .x    (X),
    .k    (k),
    .bin  (borrow_in),
    .s    (s_raw),
    .bout (borrow_out)
  );

  // A valid SYNC bit is always decoded as bit 0, whatever the stored index.
  always_comb begin
    cur        = (X_VALID && SYNC) ? B0 : state;
    k          = xs3_k(cur);
    borrow_in  = (cur == B0) ? 1'b0 : borrow;
    code       = {X, xin};
    S          = X_VALID & s_raw;
    V          = X_VALID && (cur == B3) && ((code < XS3_MIN) || (code > XS3_MAX));
    state_next = state;
    if (X_VALID) begin
      case (cur)
        B0:      state_next = B1;
        B1:      state_next = B2;
        B2:      state_next = B3;
        default: state_next = B0;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= B0;
      borrow  <= 1'b0;
      shift   <= '0;
      xin     <= '0;
      D       <= '0;
      D_VALID <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_next;
      D_VALID <= X_VALID && (cur == B3);
      if (X_VALID) begin
        borrow <= borrow_out;
        if (cur == B3) begin
          D   <= {s_raw, shift};
          ERR <= V;
        end else begin
          shift[cur] <= s_raw;
          xin[cur]   <= X;
        end
      end
    end
  end

`ifdef XS3_ERR_COUNT_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      ERR_CNT <= '0;
    else if (V && (ERR_CNT != 8'd255))
      ERR_CNT <= ERR_CNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_serial_xs3_decoder.sv
// Self-checking bench for serial_xs3_decoder: directed cases plus random digits
// against an arithmetic reference model (code - 3 mod 16).
module tb_serial_xs3_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       X, X_VALID, SYNC;
  logic       S, V, D_VALID, ERR;
  logic [3:0] D;
`ifdef XS3_ERR_COUNT_EN
  logic [7:0] ERR_CNT;
`endif

  serial_xs3_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .X       (X),
    .X_VALID (X_VALID),
    .SYNC    (SYNC),
    .S       (S),
    .V       (V),
    .D       (D),
    .D_VALID (D_VALID),
    .ERR     (ERR)
`ifdef XS3_ERR_COUNT_EN
    ,
    .ERR_CNT (ERR_CNT)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int         m_idx  = 0;
  logic [3:0] m_code = '0;
  logic [3:0] m_d    = '0;
  logic       m_err  = 1'b0;
  int         m_cnt  = 0;
  int         m_pulses = 0;

  function automatic void check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  task automatic check_regs();
    check("D", {4'd0, D}, {4'd0, m_d});
    check("ERR", {7'd0, ERR}, {7'd0, m_err});
`ifdef XS3_ERR_COUNT_EN
    check("ERR_CNT", ERR_CNT, m_cnt[7:0]);
`endif
  endtask

  // Drives one cycle of input, checks Mealy outputs, then registered outputs.
  task automatic apply_bit(input logic x, input logic v, input logic sy);
    int   idx;
    int   part;
    logic es, ev, edv;
    es = 1'b0; ev = 1'b0; edv = 1'b0; idx = 0;
    @(posedge clk); #1;
    X = x; X_VALID = v; SYNC = sy;
    if (v) begin
      idx = sy ? 0 : m_idx;
      m_code[idx] = x;
      part = int'(m_code) & ((1 << (idx + 1)) - 1);
      es = 1'(((part + 16 - 3) >> idx) & 1);
      if (idx == 3) ev = (m_code < 4'd3) || (m_code > 4'd12);
    end
    #1;
    check("S", {7'd0, S}, {7'd0, es});
    check("V", {7'd0, V}, {7'd0, ev});
    @(negedge clk); #1;
    if (v) begin
      if (idx == 3) begin
        m_d   = 4'((int'(m_code) + 13) % 16);
        m_err = ev;
        edv   = 1'b1;
        m_pulses++;
        if (ev && m_cnt < 255) m_cnt++;
      end
      m_idx = (idx + 1) % 4;
    end
    check("D_VALID", {7'd0, D_VALID}, {7'd0, edv});
    check_regs();
  endtask

  task automatic send_digit(input logic [3:0] code, input logic sync_first);
    for (int unsigned i = 0; i < 4; i++)
      apply_bit(code[i], 1'b1, (i == 0) && sync_first);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) apply_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; X_VALID = 1'b0; SYNC = 1'b0;
    #1;
    m_idx = 0; m_d = '0; m_err = 1'b0; m_cnt = 0;
    check("RST_D_VALID", {7'd0, D_VALID}, 8'd0);
    check_regs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] c;
    int         p0;
    rst_n = 1'b0; X = 1'b0; X_VALID = 1'b0; SYNC = 1'b0;
    #23;
    check("RST_D_VALID", {7'd0, D_VALID}, 8'd0);
    check_regs();
    @(posedge clk); #1 rst_n = 1'b1;

    // 0111 -> 0100
    apply_bit(1'b1, 1'b1, 1'b1);
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b0, 1'b1, 1'b0);
    check("D_0111", {4'd0, D}, 8'h04);

    // back-to-back 1100, 0011
    send_digit(4'b1100, 1'b0);
    check("D_1100", {4'd0, D}, 8'h09);
    send_digit(4'b0011, 1'b0);
    check("D_0011", {4'd0, D}, 8'h00);

    // invalid codes
    send_digit(4'b0010, 1'b0);
    check("D_0010", {4'd0, D}, 8'h0F);
    check("ERR_0010", {7'd0, ERR}, 8'd1);
    send_digit(4'b1111, 1'b0);
    check("D_1111", {4'd0, D}, 8'h0C);
`ifdef XS3_ERR_COUNT_EN
    check("ERR_CNT_2", ERR_CNT, 8'd2);
`endif
    idle(2);

    // 0111 with a 3-cycle X_VALID gap between bits 1 and 2; SYNC ignored while idle
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b1);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b1);
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b0, 1'b1, 1'b0);
    check("D_gap", {4'd0, D}, 8'h04);

    // partial digit then SYNC with 1000
    p0 = m_pulses;
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b0, 1'b1, 1'b0);
    send_digit(4'b1000, 1'b1);
    check("SYNC_pulses", 8'(m_pulses - p0), 8'd1);
    check("D_sync", {4'd0, D}, 8'h05);

    // SYNC arriving on bit 3 restarts the digit
    apply_bit(1'b0, 1'b1, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    send_digit(4'b1001, 1'b1);
    check("D_sync_b3", {4'd0, D}, 8'h06);

    // reset after bit 2, then a clean digit
    apply_bit(1'b1, 1'b1, 1'b0);
    apply_bit(1'b0, 1'b1, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    pulse_reset();
    send_digit(4'b1010, 1'b0);
    check("D_after_rst", {4'd0, D}, 8'h07);

    // random digits with gaps and occasional SYNC
    for (int unsigned n = 0; n < 300; n++) begin
      apply_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 9) == 0));
    end

    // saturation: 256 invalid codes
    pulse_reset();
    for (int unsigned n = 0; n < 256; n++) begin
      c = 4'b0000;
      send_digit(c, 1'b0);
    end
    check("D_0000", {4'd0, D}, 8'h0D);
`ifdef XS3_ERR_COUNT_EN
    check("ERR_CNT_sat", ERR_CNT, 8'd255);
    send_digit(4'b0000, 1'b0);
    check("ERR_CNT_nowrap", ERR_CNT, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
